// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: one start bit, DATA_W data bits LSB first,
// optional even/odd parity bit and 1 or 2 stop bits, with a start/busy/done handshake.
module uart_tx_cfg #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic              bit_end;

    assign bit_end = (baud_cnt == LAST_BAUD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Baud counter wraps at every bit boundary while a frame is in flight
            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        shift_reg  <= data;
                        parity_bit <= (PARITY == 2) ? ~(^data) : (^data);
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        state     <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
